// File: rtl/uiudp_tx_if.sv
// rtl/uiudp_tx_if.sv - signal bundle between uiudp_tx, the user payload side and ip_layer TX
//
// Purpose: groups the user request/FIFO handshake and the ip_layer TX handshake/byte stream.
// Modports:
//   master : the framer (uiudp_tx) - drives every O_* signal, samples every I_* signal
//   slave  : the environment (user logic + ip_layer) - the reverse
// Signals:
//   I_W_udp_req, I_W_udp_len[15:0], I_W_udp_src_port[15:0], I_W_udp_dest_port[15:0]  send request
//   O_W_udp_busy, O_W_udp_done, O_W_udp_err                                         request status
//   O_W_udp_rd, I_W_udp_data[7:0]                                                   payload FIFO pull
//   O_udp_ip_req, O_udp_ip_len[15:0], I_udp_ip_ready                                slot request
//   O_udp_ip_tvalid, O_udp_ip_tdata[7:0]                                            UDP byte stream
interface uiudp_tx_if;
   logic        I_W_udp_req;
   logic [15:0] I_W_udp_len;
   logic [15:0] I_W_udp_src_port;
   logic [15:0] I_W_udp_dest_port;
   logic        O_W_udp_busy;
   logic        O_W_udp_rd;
   logic [7:0]  I_W_udp_data;
   logic        O_W_udp_done;
   logic        O_W_udp_err;
   logic        O_udp_ip_req;
   logic [15:0] O_udp_ip_len;
   logic        I_udp_ip_ready;
   logic        O_udp_ip_tvalid;
   logic [7:0]  O_udp_ip_tdata;

   modport master (
      input  I_W_udp_req, I_W_udp_len, I_W_udp_src_port, I_W_udp_dest_port,
      input  I_W_udp_data, I_udp_ip_ready,
      output O_W_udp_busy, O_W_udp_rd, O_W_udp_done, O_W_udp_err,
      output O_udp_ip_req, O_udp_ip_len, O_udp_ip_tvalid, O_udp_ip_tdata
   );

   modport slave (
      output I_W_udp_req, I_W_udp_len, I_W_udp_src_port, I_W_udp_dest_port,
      output I_W_udp_data, I_udp_ip_ready,
      input  O_W_udp_busy, O_W_udp_rd, O_W_udp_done, O_W_udp_err,
      input  O_udp_ip_req, O_udp_ip_len, O_udp_ip_tvalid, O_udp_ip_tdata
   );
endinterface

// File: rtl/uiudp_tx.sv
// rtl/uiudp_tx.sv - UDP transmit framer: 8-byte header plus FIFO payload toward ip_layer TX
//
// Purpose: accepts a send request, obtains a slot from ip_layer, then streams the UDP header
//          (checksum 0x0000) followed by the payload pulled byte-wise from the user FIFO.
// Parameters:
//   MAX_LEN        largest accepted payload length in bytes
//   READY_TIMEOUT  cycles to wait for I_udp_ip_ready before aborting
// Ports:
//   I_T_udp_clk  TX clock (shared with ip_layer TX)
//   I_reset_n    asynchronous reset, active low
//   bus          uiudp_tx_if.master - user request/FIFO side and ip_layer side
module uiudp_tx #(
   parameter int MAX_LEN       = 1472,
   parameter int READY_TIMEOUT = 4096
) (
   input  logic       I_T_udp_clk,
   input  logic       I_reset_n,
   uiudp_tx_if.master bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int CW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(READY_TIMEOUT - 1);

   logic [2:0]    state;
   logic [15:0]   src;
   logic [15:0]   dst;
   logic [15:0]   len;
   logic [CW-1:0] cnt;
   logic [2:0]    hidx;     // index of the header byte currently on tdata
   logic [15:0]   rd_rem;   // FIFO reads still to be issued
   logic [15:0]   drem;     // payload bytes still to be shown after the current one

   logic        busy, rd, done, err, ip_req, tvalid;
   logic [15:0] ip_len;
   logic [7:0]  tdata;

   assign bus.O_W_udp_busy    = busy;
   assign bus.O_W_udp_rd      = rd;
   assign bus.O_W_udp_done    = done;
   assign bus.O_W_udp_err     = err;
   assign bus.O_udp_ip_req    = ip_req;
   assign bus.O_udp_ip_len    = ip_len;
   assign bus.O_udp_ip_tvalid = tvalid;
   assign bus.O_udp_ip_tdata  = tdata;

   // ip_len doubles as the UDP length field; it is held for the whole frame.
   function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    hdr_byte = src[15:8];
         3'd1:    hdr_byte = src[7:0];
         3'd2:    hdr_byte = dst[15:8];
         3'd3:    hdr_byte = dst[7:0];
         3'd4:    hdr_byte = ip_len[15:8];
         3'd5:    hdr_byte = ip_len[7:0];
         default: hdr_byte = 8'h00;
      endcase
   endfunction

   always_ff @(posedge I_T_udp_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state  <= S_IDLE;
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         cnt    <= '0;
         hidx   <= '0;
         rd_rem <= '0;
         drem   <= '0;
         busy   <= 1'b0;
         rd     <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         ip_req <= 1'b0;
         ip_len <= '0;
         tvalid <= 1'b0;
         tdata  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         // The FIFO has one cycle of read latency and tdata is registered, so a read
         // issued while header byte 5 is showing lands on tdata right after header byte 7.
         // Once started, reads continue back to back until all len have been issued.
         if ((rd_rem != 16'd0) &&
             (((state == S_HDR) && (hidx >= 3'd5)) || (state == S_DATA))) begin
            rd     <= 1'b1;
            rd_rem <= rd_rem - 16'd1;
         end else begin
            rd <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (bus.I_W_udp_req) begin
                  src <= bus.I_W_udp_src_port;
                  dst <= bus.I_W_udp_dest_port;
                  len <= bus.I_W_udp_len;
                  if (bus.I_W_udp_len > 16'(MAX_LEN)) begin
                     err <= 1'b1;
                  end else begin
                     busy   <= 1'b1;
                     ip_req <= 1'b1;
                     ip_len <= bus.I_W_udp_len + 16'd8;
                     cnt    <= '0;
                     state  <= S_REQ;
                  end
               end
            end

            S_REQ: begin
               if (bus.I_udp_ip_ready) begin
                  ip_req <= 1'b0;
                  hidx   <= 3'd0;
                  tvalid <= 1'b1;
                  tdata  <= src[15:8];
                  rd_rem <= len;
                  state  <= S_HDR;
               end else if (cnt == CNT_LAST) begin
                  ip_req <= 1'b0;
                  err    <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_HDR: begin
               if (hidx != 3'd7) begin
                  hidx  <= hidx + 3'd1;
                  tdata <= hdr_byte(hidx + 3'd1);
               end else if (len == 16'd0) begin
                  tvalid <= 1'b0;
                  tdata  <= '0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  tdata <= bus.I_W_udp_data;
                  drem  <= len - 16'd1;
                  state <= S_DATA;
               end
            end

            S_DATA: begin
               if (drem == 16'd0) begin
                  tvalid <= 1'b0;
                  tdata  <= '0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  tdata <= bus.I_W_udp_data;
                  drem  <= drem - 16'd1;
               end
            end

            // One dead cycle so a request coinciding with the done pulse is ignored.
            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uiudp_tx.sv
// tb/tb_uiudp_tx.sv - scoreboard bench for uiudp_tx
module tb_uiudp_tx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uiudp_tx_if bus();

   uiudp_tx #(.MAX_LEN(1472), .READY_TIMEOUT(16)) dut (
      .I_T_udp_clk (clk),
      .I_reset_n   (rst_n),
      .bus         (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] ev_q[$];
   int         len_q[$];
   logic [7:0] fifo_q[$];

   int         rd_count = 0;
   logic [7:0] pend_byte = 8'h00;
   bit         have_pend = 1'b0;
   bit         prev_tvalid = 1'b0;
   int         run = 0;

   task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // User FIFO model: a read seen in cycle t presents its byte during cycle t+1.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         have_pend = 1'b0;
      end else begin
         if (have_pend) bus.I_W_udp_data = pend_byte;
         have_pend = 1'b0;
         if (bus.O_W_udp_rd) begin
            rd_count++;
            if (fifo_q.size() == 0) begin
               chk("fifo_underflow", 32'd1, 32'd0);
            end else begin
               pend_byte = fifo_q.pop_front();
               have_pend = 1'b1;
            end
         end
      end
   end

   // Monitor: pops expected bytes and events whenever the DUT presents them.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_tvalid = 1'b0;
      end else begin
         if (bus.O_udp_ip_tvalid) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bus.O_udp_ip_tdata}, 32'hFFFF);
            else chk("tdata", {24'd0, bus.O_udp_ip_tdata}, {24'd0, exp_q.pop_front()});
            run = prev_tvalid ? run + 1 : 1;
         end else begin
            chk("tdata_idle", {24'd0, bus.O_udp_ip_tdata}, 32'd0);
         end
         if (bus.O_W_udp_done || bus.O_W_udp_err) begin
            chk("done_err_excl", {31'd0, bus.O_W_udp_done & bus.O_W_udp_err}, 32'd0);
            chk("busy_at_event", {31'd0, bus.O_W_udp_busy}, 32'd0);
            if (ev_q.size() == 0) begin
               chk("unexpected_event", {31'd0, bus.O_W_udp_done}, 32'hFFFF);
            end else begin
               logic [7:0] e;
               e = ev_q.pop_front();
               chk("event_kind", bus.O_W_udp_done ? 32'h44 : 32'h45, {24'd0, e});
               if (bus.O_W_udp_done && e == 8'h44) begin
                  chk("done_after_last", {31'd0, prev_tvalid}, 32'd1);
                  chk("frame_len", run, len_q.pop_front());
               end
            end
         end
         prev_tvalid = bus.O_udp_ip_tvalid;
      end
   end

   task queue_frame(input logic [15:0] src, input logic [15:0] dst, input int len,
                    input logic [7:0] seed, input logic [7:0] step);
      logic [15:0] ulen;
      logic [7:0]  b;
      ulen = 16'(len + 8);
      exp_q.push_back(src[15:8]);  exp_q.push_back(src[7:0]);
      exp_q.push_back(dst[15:8]);  exp_q.push_back(dst[7:0]);
      exp_q.push_back(ulen[15:8]); exp_q.push_back(ulen[7:0]);
      exp_q.push_back(8'h00);      exp_q.push_back(8'h00);
      for (int i = 0; i < len; i++) begin
         b = seed + 8'(i) * step;
         fifo_q.push_back(b);
         exp_q.push_back(b);
      end
      ev_q.push_back(8'h44);
      len_q.push_back(len + 8);
   endtask

   task start_req(input logic [15:0] src, input logic [15:0] dst, input int len);
      @(negedge clk);
      bus.I_W_udp_src_port  = src;
      bus.I_W_udp_dest_port = dst;
      bus.I_W_udp_len       = 16'(len);
      bus.I_W_udp_req       = 1'b1;
      @(negedge clk);
      bus.I_W_udp_req       = 1'b0;
   endtask

   task wait_ip_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.O_udp_ip_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("ip_req_timeout", 32'd0, 32'd1);
   endtask

   task do_frame(input logic [15:0] src, input logic [15:0] dst, input int len,
                 input logic [7:0] seed, input logic [7:0] step,
                 input int rdelay, input int inject);
      int start;
      int n;
      bit ok;
      queue_frame(src, dst, len, seed, step);
      start = rd_count;
      start_req(src, dst, len);
      wait_ip_req(ok);
      if (ok) begin
         chk("ip_len", {16'd0, bus.O_udp_ip_len}, 32'(len + 8));
         repeat (rdelay) @(negedge clk);
         bus.I_udp_ip_ready = 1'b1;
         @(negedge clk);
         bus.I_udp_ip_ready = 1'b0;
         if (inject > 0) begin
            repeat (inject) @(negedge clk);
            chk("busy_mid_frame", {31'd0, bus.O_W_udp_busy}, 32'd1);
            start_req(16'hDEAD, 16'hBEEF, 3);
         end
         n = 0;
         while (bus.O_W_udp_busy && n < len + 50) begin
            @(negedge clk);
            n++;
         end
         chk("frame_end", {31'd0, bus.O_W_udp_busy}, 32'd0);
         chk("rd_count", rd_count - start, len);
         repeat (3) begin
            @(negedge clk);
            chk("ip_req_idle", {31'd0, bus.O_udp_ip_req}, 32'd0);
         end
      end
   endtask

   initial begin
      int n;
      bit ok;
      bus.I_W_udp_req       = 1'b0;
      bus.I_W_udp_len       = '0;
      bus.I_W_udp_src_port  = '0;
      bus.I_W_udp_dest_port = '0;
      bus.I_W_udp_data      = '0;
      bus.I_udp_ip_ready    = 1'b0;

      #1;
      chk("rst_busy",   {31'd0, bus.O_W_udp_busy},    32'd0);
      chk("rst_rd",     {31'd0, bus.O_W_udp_rd},      32'd0);
      chk("rst_done",   {31'd0, bus.O_W_udp_done},    32'd0);
      chk("rst_err",    {31'd0, bus.O_W_udp_err},     32'd0);
      chk("rst_ipreq",  {31'd0, bus.O_udp_ip_req},    32'd0);
      chk("rst_iplen",  {16'd0, bus.O_udp_ip_len},    32'd0);
      chk("rst_tvalid", {31'd0, bus.O_udp_ip_tvalid}, 32'd0);
      chk("rst_tdata",  {24'd0, bus.O_udp_ip_tdata},  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic frame: 1F 90 1F 91 00 0C 00 00 11 22 33 44
      do_frame(16'h1F90, 16'h1F91, 4, 8'h11, 8'h11, 2, 0);

      // Header-only frame
      do_frame(16'h1234, 16'hABCD, 0, 8'h00, 8'h00, 0, 0);

      // Oversize request rejected
      ev_q.push_back(8'h45);
      start_req(16'h0001, 16'h0002, 1473);
      repeat (6) begin
         chk("reject_ipreq", {31'd0, bus.O_udp_ip_req}, 32'd0);
         chk("reject_busy",  {31'd0, bus.O_W_udp_busy}, 32'd0);
         @(negedge clk);
      end
      chk("reject_err_seen", ev_q.size(), 0);

      // Ready timeout
      ev_q.push_back(8'h45);
      start_req(16'h0003, 16'h0004, 5);
      wait_ip_req(ok);
      n = 0;
      while (bus.O_udp_ip_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_req_cycles", n, 16);
      chk("timeout_busy", {31'd0, bus.O_W_udp_busy}, 32'd0);
      @(negedge clk);
      chk("timeout_err_seen", ev_q.size(), 0);

      // Max-length frame with an ignored second request mid-DATA
      do_frame(16'hC000, 16'h0035, 1472, 8'h00, 8'h01, 0, 100);

      // Reset in the middle of a frame
      queue_frame(16'h5555, 16'hAAAA, 6, 8'h70, 8'h03);
      start_req(16'h5555, 16'hAAAA, 6);
      wait_ip_req(ok);
      bus.I_udp_ip_ready = 1'b1;
      @(negedge clk);
      bus.I_udp_ip_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.O_udp_ip_tvalid) n++;
         if (n == 10) break;
         @(negedge clk);
      end
      chk("reset_reached_byte10", n, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", {31'd0, bus.O_udp_ip_tvalid}, 32'd0);
      chk("arst_tdata",  {24'd0, bus.O_udp_ip_tdata},  32'd0);
      chk("arst_busy",   {31'd0, bus.O_W_udp_busy},    32'd0);
      chk("arst_rd",     {31'd0, bus.O_W_udp_rd},      32'd0);
      chk("arst_iplen",  {16'd0, bus.O_udp_ip_len},    32'd0);
      exp_q.delete();
      fifo_q.delete();
      ev_q.delete();
      len_q.delete();
      repeat (2) @(negedge clk);
      chk("arst_done", {31'd0, bus.O_W_udp_done}, 32'd0);
      chk("arst_err",  {31'd0, bus.O_W_udp_err},  32'd0);
      rst_n = 1'b1;
      do_frame(16'h0102, 16'h0304, 2, 8'hE0, 8'h01, 1, 0);

      repeat (5) @(negedge clk);
      chk("drain_bytes",  exp_q.size(),  0);
      chk("drain_events", ev_q.size(),   0);
      chk("drain_fifo",   fifo_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
